pong_game_ctrl: RTL and testbench
=================================

// Module: pong_game_ctrl
// PURPOSE
//  Parametrised pong game-state controller: owns scores, serve countdown, pause and win detection.
//  Sits between ball/paddle control and pixel mixing in the pong top level.
//  Consumes tile-grid positions (column/row >> 4) and drives the ball-enable and score outputs.
//  Adds a frame-timed serve delay, pause toggle, edge-detected buttons, a game-over state and a winner flag.
// PARAMETERS
//  c_SCORE_WIDTH        4   width of each score counter
//  c_SCORE_LIMIT        9   score that wins the game (1 .. 2**c_SCORE_WIDTH-1)
//  c_PADDLE_HEIGHT      6   paddle height in tiles
//  c_GAME_WINDOW_WIDTH  40  playfield width in tiles; P2 goal column = width-1
//  c_POS_WIDTH          6   width of tile X/Y positions
//  c_SERVE_FRAMES       60  frame ticks in SERVE before the ball moves (>= 1)
// PORTS
//  i_Clk            in   1               pixel clock
//  i_Rst_n          in   1               async active-low reset
//  i_FrameTick      in   1               one-cycle strobe per video frame
//  i_StartGame      in   1               start button (level; rising edge used)
//  i_Pause          in   1               pause button (level; rising edge used)
//  i_Ball_X_Pos     in   c_POS_WIDTH     ball tile column
//  i_Ball_Y_Pos     in   c_POS_WIDTH     ball tile row
//  i_Paddle1_Y_Pos  in   c_POS_WIDTH     top tile of P1 paddle (column 0)
//  i_Paddle2_Y_Pos  in   c_POS_WIDTH     top tile of P2 paddle (column width-1)
//  o_State          out  3               IDLE=0 SERVE=1 RUNNING=2 PAUSED=3 P1_SCORES=4 P2_SCORES=5 GAME_OVER=6
//  o_GameRunning    out  1               1 only in RUNNING (enables ball motion)
//  o_ServeDir       out  1               0 = serve toward P1, 1 = toward P2
//  o_P1_ScoreCount  out  c_SCORE_WIDTH   P1 score
//  o_P2_ScoreCount  out  c_SCORE_WIDTH   P2 score
//  o_GameOver       out  1               1 in GAME_OVER
//  o_Winner         out  1               0 = P1 won, 1 = P2 won; valid while o_GameOver
// BEHAVIOUR
//  Reset (async assert, sync release): state IDLE, scores 0, countdown 0, o_ServeDir 0, o_Winner 0,
//   button history 0; hence o_GameRunning 0, o_GameOver 0. Reset mid-game abandons the game immediately.
//  Start/pause edges: registered prev value; edge = level & ~prev. A held button yields one event only.
//  All outputs are decoded from registered state/counters; no input-to-output combinational path.
//  Hit window: paddle P covers rows P .. P+c_PADDLE_HEIGHT-1 inclusive; compare at c_POS_WIDTH+1 bits (no wrap).
//  IDLE: start edge -> SERVE, countdown <= c_SERVE_FRAMES. Pause ignored.
//  SERVE: each i_FrameTick decrements; tick while countdown==1 -> RUNNING. Start/pause ignored.
//  RUNNING, priority order:
//   1) ball X==0 and Y outside P1 window -> P2_SCORES
//   2) ball X==width-1 and Y outside P2 window -> P1_SCORES
//   3) pause edge -> PAUSED
//  PAUSED: pause edge -> RUNNING; countdown/scores held; start ignored.
//  P1_SCORES (1 cycle): P1 += 1; if new value == c_SCORE_LIMIT -> GAME_OVER, o_Winner<=0;
//   else -> SERVE, countdown reload, o_ServeDir<=1 (serve toward the player who missed).
//  P2_SCORES: mirror; o_Winner<=1 on win, o_ServeDir<=0 on serve.
//  GAME_OVER: scores frozen; start edge -> both scores 0, SERVE with countdown reload, o_ServeDir held.
//  Unused encoding 7 -> IDLE next cycle.
//  Scores never wrap: limit checked before reaching 2**c_SCORE_WIDTH.
// TESTING
//  Reset low mid-RUNNING with P1=3 -> same cycle state 0, scores 0, o_GameRunning 0.
//  Start edge, SERVE_FRAMES=3 -> o_GameRunning rises the cycle after the 3rd frame tick, not before.
//  RUNNING, ball X=0 Y=10, paddle1 Y=4 (window 4..9) -> P2_SCORES, P2 +1, SERVE, o_ServeDir=0;
//   same with Y=9 -> no score.
//  Both goal conditions in one cycle (width=1 corner) -> P2_SCORES wins priority.
//  Pause edge in RUNNING -> PAUSED; held pause gives no toggle; second edge -> RUNNING; ball miss while paused ignored.
//  P1 at 8, P2 misses -> P1=9, GAME_OVER, o_Winner=0; start edge -> scores 0, SERVE.

Source files
------------

// File: rtl/pong_game_ctrl_if.sv
// Pong game-state controller bus.
//  master: drives frame tick, buttons and tile positions; receives game state.
//  slave : the controller itself.
//  Inputs : i_FrameTick, i_StartGame, i_Pause, i_Ball_X_Pos, i_Ball_Y_Pos,
//           i_Paddle1_Y_Pos, i_Paddle2_Y_Pos
//  Outputs: o_State, o_GameRunning, o_ServeDir, o_P1_ScoreCount, o_P2_ScoreCount,
//           o_GameOver, o_Winner
interface pong_game_ctrl_if #(
    parameter int unsigned c_POS_WIDTH   = 6,
    parameter int unsigned c_SCORE_WIDTH = 4
);
    logic                     i_FrameTick;
    logic                     i_StartGame;
    logic                     i_Pause;
    logic [c_POS_WIDTH-1:0]   i_Ball_X_Pos;
    logic [c_POS_WIDTH-1:0]   i_Ball_Y_Pos;
    logic [c_POS_WIDTH-1:0]   i_Paddle1_Y_Pos;
    logic [c_POS_WIDTH-1:0]   i_Paddle2_Y_Pos;
    logic [2:0]               o_State;
    logic                     o_GameRunning;
    logic                     o_ServeDir;
    logic [c_SCORE_WIDTH-1:0] o_P1_ScoreCount;
    logic [c_SCORE_WIDTH-1:0] o_P2_ScoreCount;
    logic                     o_GameOver;
    logic                     o_Winner;

    modport master (
        output i_FrameTick, i_StartGame, i_Pause, i_Ball_X_Pos, i_Ball_Y_Pos,
               i_Paddle1_Y_Pos, i_Paddle2_Y_Pos,
        input  o_State, o_GameRunning, o_ServeDir, o_P1_ScoreCount, o_P2_ScoreCount,
               o_GameOver, o_Winner
    );

    modport slave (
        input  i_FrameTick, i_StartGame, i_Pause, i_Ball_X_Pos, i_Ball_Y_Pos,
               i_Paddle1_Y_Pos, i_Paddle2_Y_Pos,
        output o_State, o_GameRunning, o_ServeDir, o_P1_ScoreCount, o_P2_ScoreCount,
               o_GameOver, o_Winner
    );
endinterface

// File: rtl/pong_game_ctrl.sv
// Pong game-state controller: scores, frame-timed serve countdown, pause toggle and
// win detection. Sits between ball/paddle control and pixel mixing.
//  i_Clk   : pixel clock
//  i_Rst_n : asynchronous active-low reset
//  bus     : pong_game_ctrl_if slave (tick/buttons/tile positions in, game state out)
// All outputs decode registered state only.
module pong_game_ctrl #(
    parameter int unsigned c_SCORE_WIDTH       = 4,
    parameter int unsigned c_SCORE_LIMIT       = 9,
    parameter int unsigned c_PADDLE_HEIGHT     = 6,
    parameter int unsigned c_GAME_WINDOW_WIDTH = 40,
    parameter int unsigned c_POS_WIDTH         = 6,
    parameter int unsigned c_SERVE_FRAMES      = 60
) (
    input logic             i_Clk,
    input logic             i_Rst_n,
    pong_game_ctrl_if.slave bus
);
    localparam int unsigned CntW = $clog2(c_SERVE_FRAMES + 1);
    localparam int unsigned SW1  = c_SCORE_WIDTH + 1;
    localparam int unsigned PW1  = c_POS_WIDTH + 1;

    localparam logic [CntW-1:0]        ServeLoad  = CntW'(c_SERVE_FRAMES);
    localparam logic [c_POS_WIDTH-1:0] P2Col      = c_POS_WIDTH'(c_GAME_WINDOW_WIDTH - 1);
    localparam logic [SW1-1:0]         ScoreLimit = SW1'(c_SCORE_LIMIT);
    localparam logic [PW1-1:0]         PadSpan    = PW1'(c_PADDLE_HEIGHT - 1);

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StServe    = 3'd1,
        StRunning  = 3'd2,
        StPaused   = 3'd3,
        StP1Scores = 3'd4,
        StP2Scores = 3'd5,
        StGameOver = 3'd6
    } state_e;

    state_e                   state_q, state_d;
    logic [c_SCORE_WIDTH-1:0] p1_q, p1_d, p2_q, p2_d;
    logic [CntW-1:0]          cnt_q, cnt_d;
    logic                     serve_dir_q, serve_dir_d;
    logic                     winner_q, winner_d;
    logic                     start_prev_q, pause_prev_q;

    logic           start_edge, pause_edge;
    logic [PW1-1:0] ball_y, p1_top, p2_top;
    logic           p1_miss, p2_miss;
    logic [SW1-1:0] p1_inc, p2_inc;

    assign start_edge = bus.i_StartGame & ~start_prev_q;
    assign pause_edge = bus.i_Pause & ~pause_prev_q;

    // One extra bit so a paddle near the bottom does not wrap its window.
    assign ball_y  = {1'b0, bus.i_Ball_Y_Pos};
    assign p1_top  = {1'b0, bus.i_Paddle1_Y_Pos};
    assign p2_top  = {1'b0, bus.i_Paddle2_Y_Pos};
    assign p1_miss = (ball_y < p1_top) || (ball_y > p1_top + PadSpan);
    assign p2_miss = (ball_y < p2_top) || (ball_y > p2_top + PadSpan);

    // Widened so the limit test happens before the counter could wrap.
    assign p1_inc = {1'b0, p1_q} + SW1'(1);
    assign p2_inc = {1'b0, p2_q} + SW1'(1);

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q      <= StIdle;
            p1_q         <= '0;
            p2_q         <= '0;
            cnt_q        <= '0;
            serve_dir_q  <= 1'b0;
            winner_q     <= 1'b0;
            start_prev_q <= 1'b0;
            pause_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            p1_q         <= p1_d;
            p2_q         <= p2_d;
            cnt_q        <= cnt_d;
            serve_dir_q  <= serve_dir_d;
            winner_q     <= winner_d;
            start_prev_q <= bus.i_StartGame;
            pause_prev_q <= bus.i_Pause;
        end
    end

    always_comb begin
        state_d     = state_q;
        p1_d        = p1_q;
        p2_d        = p2_q;
        cnt_d       = cnt_q;
        serve_dir_d = serve_dir_q;
        winner_d    = winner_q;
        case (state_q)
            StIdle: begin
                if (start_edge) begin
                    state_d = StServe;
                    cnt_d   = ServeLoad;
                end
            end
            StServe: begin
                if (bus.i_FrameTick) begin
                    if (cnt_q <= CntW'(1)) begin
                        state_d = StRunning;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CntW'(1);
                    end
                end
            end
            StRunning: begin
                // Left goal beats right goal when both columns coincide.
                if (bus.i_Ball_X_Pos == '0 && p1_miss) begin
                    state_d = StP2Scores;
                end else if (bus.i_Ball_X_Pos == P2Col && p2_miss) begin
                    state_d = StP1Scores;
                end else if (pause_edge) begin
                    state_d = StPaused;
                end
            end
            StPaused: begin
                if (pause_edge) state_d = StRunning;
            end
            StP1Scores: begin
                p1_d = p1_inc[c_SCORE_WIDTH-1:0];
                if (p1_inc == ScoreLimit) begin
                    state_d  = StGameOver;
                    winner_d = 1'b0;
                end else begin
                    state_d     = StServe;
                    cnt_d       = ServeLoad;
                    serve_dir_d = 1'b1;
                end
            end
            StP2Scores: begin
                p2_d = p2_inc[c_SCORE_WIDTH-1:0];
                if (p2_inc == ScoreLimit) begin
                    state_d  = StGameOver;
                    winner_d = 1'b1;
                end else begin
                    state_d     = StServe;
                    cnt_d       = ServeLoad;
                    serve_dir_d = 1'b0;
                end
            end
            StGameOver: begin
                if (start_edge) begin
                    p1_d    = '0;
                    p2_d    = '0;
                    state_d = StServe;
                    cnt_d   = ServeLoad;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.o_State         = state_q;
        bus.o_GameRunning   = (state_q == StRunning);
        bus.o_GameOver      = (state_q == StGameOver);
        bus.o_ServeDir      = serve_dir_q;
        bus.o_Winner        = winner_q;
        bus.o_P1_ScoreCount = p1_q;
        bus.o_P2_ScoreCount = p2_q;
    end
endmodule

// File: tb/tb_pong_game_ctrl.sv
// Self-checking bench for pong_game_ctrl: vector table plus hand sequences for
// scoring to a win, restart, async reset mid-game and the width=1 goal-priority corner.
module tb_pong_game_ctrl;
    localparam int unsigned PW = 6;
    localparam int unsigned SW = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    pong_game_ctrl_if #(.c_POS_WIDTH(PW), .c_SCORE_WIDTH(SW)) bus ();
    pong_game_ctrl_if #(.c_POS_WIDTH(PW), .c_SCORE_WIDTH(SW)) bus_w1 ();

    pong_game_ctrl #(
        .c_SCORE_WIDTH      (SW),
        .c_SCORE_LIMIT      (9),
        .c_PADDLE_HEIGHT    (6),
        .c_GAME_WINDOW_WIDTH(40),
        .c_POS_WIDTH        (PW),
        .c_SERVE_FRAMES     (3)
    ) u_dut (
        .i_Clk  (clk),
        .i_Rst_n(rst_n),
        .bus    (bus)
    );

    pong_game_ctrl #(
        .c_SCORE_WIDTH      (SW),
        .c_SCORE_LIMIT      (9),
        .c_PADDLE_HEIGHT    (6),
        .c_GAME_WINDOW_WIDTH(1),
        .c_POS_WIDTH        (PW),
        .c_SERVE_FRAMES     (1)
    ) u_dut_w1 (
        .i_Clk  (clk),
        .i_Rst_n(rst_n),
        .bus    (bus_w1)
    );

    typedef struct packed {
        logic [2:0] st;
        logic       run;
        logic       dir;
        logic [3:0] p1;
        logic [3:0] p2;
        logic       go;
        logic       win;
    } exp_t;

    typedef struct packed {
        logic       tick;
        logic       start;
        logic       pause;
        logic [5:0] bx;
        logic [5:0] by;
        logic [5:0] p1y;
        logic [5:0] p2y;
        exp_t       ex;
    } vec_t;

    int   n_cmp  = 0;
    int   n_fail = 0;
    exp_t sb_q[$];
    vec_t vt[25];
    int   m_p1, m_p2;
    logic m_dir;

    function automatic exp_t e(input logic [2:0] st, input logic dir, input logic [3:0] p1,
                               input logic [3:0] p2, input logic win);
        return {st, st == 3'd2, dir, p1, p2, st == 3'd6, win};
    endfunction

    function automatic vec_t v(input logic tick, input logic start, input logic pause,
                               input logic [5:0] bx, input logic [5:0] by,
                               input logic [5:0] p1y, input logic [5:0] p2y, input exp_t ex);
        return {tick, start, pause, bx, by, p1y, p2y, ex};
    endfunction

    function automatic exp_t sample_main();
        return {bus.o_State, bus.o_GameRunning, bus.o_ServeDir, bus.o_P1_ScoreCount,
                bus.o_P2_ScoreCount, bus.o_GameOver, bus.o_Winner};
    endfunction

    task automatic check_exp(input string what, input exp_t act, input exp_t ex);
        n_cmp++;
        if (act !== ex) begin
            n_fail++;
            $display("FAIL %s: got st=%0d run=%0b dir=%0b p1=%0d p2=%0d go=%0b win=%0b, want st=%0d run=%0b dir=%0b p1=%0d p2=%0d go=%0b win=%0b",
                     what, act.st, act.run, act.dir, act.p1, act.p2, act.go, act.win,
                     ex.st, ex.run, ex.dir, ex.p1, ex.p2, ex.go, ex.win);
        end
    endtask

    task automatic check32(input string what, input logic [31:0] act, input logic [31:0] ex);
        n_cmp++;
        if (act !== ex) begin
            n_fail++;
            $display("FAIL %s: got %0d want %0d", what, act, ex);
        end
    endtask

    task automatic drive(input logic tick, input logic start, input logic pause,
                         input logic [5:0] bx, input logic [5:0] by,
                         input logic [5:0] p1y, input logic [5:0] p2y);
        bus.i_FrameTick     = tick;
        bus.i_StartGame     = start;
        bus.i_Pause         = pause;
        bus.i_Ball_X_Pos    = bx;
        bus.i_Ball_Y_Pos    = by;
        bus.i_Paddle1_Y_Pos = p1y;
        bus.i_Paddle2_Y_Pos = p2y;
    endtask

    // Expectation is queued with the stimulus and retired one cycle later.
    task automatic step(input string what, input exp_t ex);
        sb_q.push_back(ex);
        @(posedge clk);
        #1;
        check_exp(what, sample_main(), sb_q.pop_front());
    endtask

    task automatic serve_ticks();
        drive(1, 0, 0, 20, 20, 4, 4);
        step("serve_t1", e(3'd1, m_dir, 4'(m_p1), 4'(m_p2), 0));
        step("serve_t2", e(3'd1, m_dir, 4'(m_p1), 4'(m_p2), 0));
        step("serve_t3", e(3'd2, m_dir, 4'(m_p1), 4'(m_p2), 0));
        drive(0, 0, 0, 20, 20, 4, 4);
    endtask

    // P2 misses at the right goal column; P1 scores.
    task automatic p1_point();
        drive(0, 0, 0, 39, 40, 4, 4);
        step("p1_miss", e(3'd4, m_dir, 4'(m_p1), 4'(m_p2), 0));
        m_p1++;
        drive(0, 0, 0, 20, 20, 4, 4);
        if (m_p1 == 9) begin
            step("p1_win", e(3'd6, m_dir, 4'(m_p1), 4'(m_p2), 0));
        end else begin
            m_dir = 1'b1;
            step("p1_serve", e(3'd1, m_dir, 4'(m_p1), 4'(m_p2), 0));
            serve_ticks();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        drive(0, 0, 0, 20, 20, 4, 4);
        bus_w1.i_FrameTick     = 1'b0;
        bus_w1.i_StartGame     = 1'b0;
        bus_w1.i_Pause         = 1'b0;
        bus_w1.i_Ball_X_Pos    = '0;
        bus_w1.i_Ball_Y_Pos    = 6'd2;
        bus_w1.i_Paddle1_Y_Pos = '0;
        bus_w1.i_Paddle2_Y_Pos = '0;

        vt[0]  = v(0, 0, 0, 20, 20, 4, 4, e(3'd0, 0, 0, 0, 0));
        vt[1]  = v(0, 0, 1, 20, 20, 4, 4, e(3'd0, 0, 0, 0, 0));
        vt[2]  = v(0, 1, 0, 20, 20, 4, 4, e(3'd1, 0, 0, 0, 0));
        vt[3]  = v(0, 1, 0, 20, 20, 4, 4, e(3'd1, 0, 0, 0, 0));
        vt[4]  = v(1, 0, 0, 20, 20, 4, 4, e(3'd1, 0, 0, 0, 0));
        vt[5]  = v(1, 0, 0, 20, 20, 4, 4, e(3'd1, 0, 0, 0, 0));
        vt[6]  = v(0, 0, 0, 20, 20, 4, 4, e(3'd1, 0, 0, 0, 0));
        vt[7]  = v(1, 0, 0, 20, 20, 4, 4, e(3'd2, 0, 0, 0, 0));
        vt[8]  = v(0, 0, 0, 0, 9, 4, 4, e(3'd2, 0, 0, 0, 0));
        vt[9]  = v(0, 0, 0, 0, 10, 4, 4, e(3'd5, 0, 0, 0, 0));
        vt[10] = v(0, 0, 0, 20, 20, 4, 4, e(3'd1, 0, 0, 1, 0));
        vt[11] = v(1, 0, 0, 20, 20, 4, 4, e(3'd1, 0, 0, 1, 0));
        vt[12] = v(1, 0, 0, 20, 20, 4, 4, e(3'd1, 0, 0, 1, 0));
        vt[13] = v(1, 0, 0, 20, 20, 4, 4, e(3'd2, 0, 0, 1, 0));
        vt[14] = v(0, 0, 0, 39, 3, 4, 4, e(3'd4, 0, 0, 1, 0));
        vt[15] = v(0, 0, 0, 20, 20, 4, 4, e(3'd1, 1, 1, 1, 0));
        vt[16] = v(1, 0, 0, 20, 20, 4, 4, e(3'd1, 1, 1, 1, 0));
        vt[17] = v(1, 0, 0, 20, 20, 4, 4, e(3'd1, 1, 1, 1, 0));
        vt[18] = v(1, 0, 0, 20, 20, 4, 4, e(3'd2, 1, 1, 1, 0));
        vt[19] = v(0, 0, 0, 39, 4, 4, 4, e(3'd2, 1, 1, 1, 0));
        vt[20] = v(0, 0, 1, 20, 20, 4, 4, e(3'd3, 1, 1, 1, 0));
        vt[21] = v(0, 0, 1, 20, 20, 4, 4, e(3'd3, 1, 1, 1, 0));
        vt[22] = v(0, 0, 0, 0, 30, 4, 4, e(3'd3, 1, 1, 1, 0));
        vt[23] = v(0, 0, 1, 20, 20, 4, 4, e(3'd2, 1, 1, 1, 0));
        vt[24] = v(0, 1, 0, 20, 20, 4, 4, e(3'd2, 1, 1, 1, 0));

        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_exp("reset_state", sample_main(), e(3'd0, 0, 0, 0, 0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 25; i++) begin
            drive(vt[i].tick, vt[i].start, vt[i].pause, vt[i].bx, vt[i].by,
                  vt[i].p1y, vt[i].p2y);
            step($sformatf("vec%0d", i), vt[i].ex);
        end

        // Play P1 from 1 up to the winning score.
        m_p1  = 1;
        m_p2  = 1;
        m_dir = 1'b1;
        drive(0, 0, 0, 20, 20, 4, 4);
        while (m_p1 < 9) p1_point();
        step("game_over_hold", e(3'd6, 1, 9, 1, 0));

        // Restart clears scores; serve direction is kept.
        m_p1 = 0;
        m_p2 = 0;
        drive(0, 1, 0, 20, 20, 4, 4);
        step("restart", e(3'd1, 1, 0, 0, 0));
        bus.i_FrameTick = 1'b1;
        step("restart_t1_held", e(3'd1, 1, 0, 0, 0));
        step("restart_t2", e(3'd1, 1, 0, 0, 0));
        step("restart_t3", e(3'd2, 1, 0, 0, 0));
        drive(0, 0, 0, 20, 20, 4, 4);
        repeat (3) p1_point();

        // Asynchronous reset mid-RUNNING with P1=3 takes effect between edges.
        check32("pre_reset_p1", 32'(bus.o_P1_ScoreCount), 32'd3);
        #3 rst_n = 1'b0;
        #1;
        check_exp("async_reset", sample_main(), e(3'd0, 0, 0, 0, 0));
        @(negedge clk);
        rst_n = 1'b1;

        // Width=1: both goals share column 0; P2 scoring takes priority.
        @(posedge clk);
        #1;
        bus_w1.i_StartGame = 1'b1;
        @(posedge clk);
        #1;
        check32("w1_serve", 32'(bus_w1.o_State), 32'd1);
        bus_w1.i_StartGame = 1'b0;
        bus_w1.i_FrameTick = 1'b1;
        @(posedge clk);
        #1;
        check32("w1_running", 32'(bus_w1.o_State), 32'd2);
        bus_w1.i_FrameTick  = 1'b0;
        bus_w1.i_Ball_Y_Pos = 6'd30;
        @(posedge clk);
        #1;
        check32("w1_priority_state", 32'(bus_w1.o_State), 32'd5);
        bus_w1.i_Ball_Y_Pos = 6'd2;
        @(posedge clk);
        #1;
        check32("w1_after_state", 32'(bus_w1.o_State), 32'd1);
        check32("w1_p2", 32'(bus_w1.o_P2_ScoreCount), 32'd1);
        check32("w1_p1", 32'(bus_w1.o_P1_ScoreCount), 32'd0);
        check32("w1_dir", 32'(bus_w1.o_ServeDir), 32'd0);

        if (sb_q.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d left want 0", sb_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
